// File: rtl/sprite_dma_if.sv
// sprite_dma_if: beam position, DMA enable and register bus in; dma, fetch address and destination register out
interface sprite_dma_if;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic dmaen;
  logic [8:1] reg_address_in;
  logic [15:0] data_in;
  logic dma;
  logic [20:1] address_out;
  logic [8:1] reg_address_out;
  modport master (
    output hpos, vpos, dmaen, reg_address_in, data_in,
    input dma, address_out, reg_address_out
  );
  modport slave (
    input hpos, vpos, dmaen, reg_address_in, data_in,
    output dma, address_out, reg_address_out
  );
endinterface

// File: rtl/sprite_dma.sv
// sprite_dma: eight-sprite slot DMA engine; clk, async reset, bus (hpos/vpos/dmaen/reg bus in; dma/address_out/reg_address_out out)
module sprite_dma #(
  parameter logic [8:0] SLOT0 = 9'h015,
  parameter logic [8:0] VBL_END = 9'd25
) (
  input logic clk,
  input logic reset,
  sprite_dma_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CTRL, WAIT, ACTIVE} st_t;
  st_t st [8];
  st_t st_n [8];
  logic [20:1] ptr [8];
  logic [8:0] vstart [8];
  logic [8:0] vstop [8];
  logic [8:0] off;
  logic [2:0] sn;
  logic sb, slot, fetch, line_start, ptr_wr, pos_wr, ctl_wr;
  assign off = bus.hpos - SLOT0;
  assign sn = off[4:2];
  assign sb = off[1];
  assign slot = bus.hpos >= SLOT0 && off < 9'd32 && !off[0];
  assign fetch = slot && bus.dmaen && (st[sn] == CTRL || st[sn] == ACTIVE);
  assign line_start = bus.hpos == '0;
  assign ptr_wr = bus.reg_address_in[8:5] == 4'b1001;
  assign pos_wr = bus.reg_address_in[8:6] == 3'b101 && bus.reg_address_in[2:1] == 2'b00;
  assign ctl_wr = bus.reg_address_in[8:6] == 3'b101 && bus.reg_address_in[2:1] == 2'b01;
  assign bus.dma = fetch;
  assign bus.address_out = fetch ? ptr[sn] : '0;
  assign bus.reg_address_out = fetch ? {3'b101, sn, st[sn] == ACTIVE, sb} : 8'hFF;
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      st_n[i] = st[i];
      if (line_start && bus.vpos == VBL_END) st_n[i] = CTRL;
      else if (line_start && st[i] == WAIT && bus.vpos == vstart[i] && vstart[i] != vstop[i]) st_n[i] = ACTIVE;
      else if (line_start && st[i] == ACTIVE && bus.vpos == vstop[i]) st_n[i] = CTRL;
      else if (fetch && sb && sn == 3'(i) && st[i] == CTRL) st_n[i] = WAIT;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) st[i] <= IDLE;
    end else begin
      for (int i = 0; i < 8; i++) st[i] <= st_n[i];
    end
  end
  // a pointer write to the sprite being fetched suppresses the increment so the CPU value wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        ptr[i] <= '0;
        vstart[i] <= '0;
        vstop[i] <= '0;
      end
    end else begin
      if (fetch && !(ptr_wr && bus.reg_address_in[4:2] == sn)) ptr[sn] <= ptr[sn] + 1'b1;
      if (ptr_wr && bus.reg_address_in[1]) ptr[bus.reg_address_in[4:2]][15:1] <= bus.data_in[15:1];
      else if (ptr_wr) ptr[bus.reg_address_in[4:2]][20:16] <= bus.data_in[4:0];
      if (pos_wr) vstart[bus.reg_address_in[5:3]][7:0] <= bus.data_in[15:8];
      if (ctl_wr) begin
        vstop[bus.reg_address_in[5:3]][7:0] <= bus.data_in[15:8];
        vstart[bus.reg_address_in[5:3]][8] <= bus.data_in[2];
        vstop[bus.reg_address_in[5:3]][8] <= bus.data_in[1];
      end
    end
  end
endmodule

// File: tb/tb_sprite_dma.sv
// tb_sprite_dma: scoreboard bench for sprite_dma slot fetches, pointer handling and vertical windows
module tb_sprite_dma;
  localparam logic [8:0] SLOT0 = 9'h015;
  typedef struct {
    logic [8:0] h;
    logic [20:1] a;
    logic [8:1] r;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  exp_t sb [$];
  logic [20:1] m_ptr [8];
  logic [15:0] mem [logic [20:1]];
  sprite_dma_if b ();
  sprite_dma dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;

  function automatic logic [15:0] rd(input logic [20:1] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  task automatic exp_one(input int n, input logic act, input logic bsel);
    logic [8:0] r9;
    r9 = 9'h140 + 9'(8 * n) + (act ? 9'd4 : 9'd0) + (bsel ? 9'd2 : 9'd0);
    sb.push_back('{SLOT0 + 9'(4 * n) + (bsel ? 9'd2 : 9'd0), m_ptr[n], r9[8:1]});
    m_ptr[n] = m_ptr[n] + 20'd1;
  endtask

  task automatic exp_all_ctrl();
    for (int n = 0; n < 8; n++) begin
      exp_one(n, 1'b0, 1'b0);
      exp_one(n, 1'b0, 1'b1);
    end
  endtask

  task automatic cpu_write(input logic [8:0] a9, input logic [15:0] d);
    @(negedge clk);
    b.hpos = 9'h100;
    b.reg_address_in = a9[8:1];
    b.data_in = d;
    @(posedge clk);
    #1 b.reg_address_in = 8'hFF;
    b.data_in = 16'h0000;
  endtask

  task automatic write_ptr(input int n, input logic [20:1] p);
    cpu_write(9'h120 + 9'(4 * n), {11'd0, p[20:16]});
    cpu_write(9'h122 + 9'(4 * n), {p[15:1], 1'b0});
    m_ptr[n] = p;
  endtask

  task automatic run_line(input logic [8:0] vp, input logic en, input logic [8:0] oh,
                          input logic [8:0] oa9, input logic [15:0] od);
    exp_t e;
    for (int h = 0; h < 64; h++) begin
      @(negedge clk);
      b.hpos = 9'(h);
      b.vpos = vp;
      b.dmaen = en;
      b.reg_address_in = 8'hFF;
      b.data_in = 16'h0000;
      #1;
      tests++;
      if (sb.size() > 0 && sb[0].h == 9'(h)) begin
        e = sb.pop_front();
        if (b.dma !== 1'b1 || b.address_out !== e.a || b.reg_address_out !== e.r) begin
          fails++;
          $display("FAIL fetch v=%0d h=%h: dma=%b addr=%h reg=%h, expected dma=1 addr=%h reg=%h",
                   vp, h, b.dma, b.address_out, b.reg_address_out, e.a, e.r);
        end
      end else if (b.dma !== 1'b0 || b.address_out !== 20'h0 || b.reg_address_out !== 8'hFF) begin
        fails++;
        $display("FAIL idle v=%0d h=%h: dma=%b addr=%h reg=%h, expected dma=0 addr=0 reg=ff",
                 vp, h, b.dma, b.address_out, b.reg_address_out);
      end
      if (9'(h) == oh) begin
        b.reg_address_in = oa9[8:1];
        b.data_in = od;
      end else if (b.dma === 1'b1) begin
        b.reg_address_in = b.reg_address_out;
        b.data_in = rd(b.address_out);
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing v=%0d: %0d fetches left, expected 0", vp, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1 tests++;
    if (b.dma !== 1'b0 || b.address_out !== 20'h0 || b.reg_address_out !== 8'hFF) begin
      fails++;
      $display("FAIL reset: dma=%b addr=%h reg=%h, expected 0/0/ff", b.dma, b.address_out, b.reg_address_out);
    end
    reset = 1'b0;
    for (int n = 0; n < 8; n++) m_ptr[n] = '0;
    run_line(9'd10, 1'b1, 9'h1FF, 9'h1FE, 16'h0);
  endtask

  task automatic test_ptr_ctrl();
    for (int n = 0; n < 7; n++) write_ptr(n, 20'h01000 + 20'(n * 'h100));
    write_ptr(7, 20'hFFFFF);
    mem[20'h01000] = 16'h3040;
    mem[20'h01001] = 16'h3200;
    mem[20'h01100] = 16'h3C00;
    mem[20'h01101] = 16'h3C00;
    exp_all_ctrl();
    run_line(9'd25, 1'b1, 9'h1FF, 9'h1FE, 16'h0);
  endtask

  task automatic test_active();
    for (int v = 26; v < 48; v++) run_line(9'(v), 1'b1, 9'h1FF, 9'h1FE, 16'h0);
    for (int v = 48; v < 50; v++) begin
      exp_one(0, 1'b1, 1'b0);
      exp_one(0, 1'b1, 1'b1);
      run_line(9'(v), 1'b1, 9'h1FF, 9'h1FE, 16'h0);
    end
    exp_one(0, 1'b0, 1'b0);
    exp_one(0, 1'b0, 1'b1);
    run_line(9'd50, 1'b1, 9'h1FF, 9'h1FE, 16'h0);
  endtask

  task automatic test_equal_start_stop();
    for (int v = 51; v < 63; v++) run_line(9'(v), 1'b1, 9'h1FF, 9'h1FE, 16'h0);
  endtask

  task automatic test_dmaen_and_collision();
    write_ptr(0, 20'h02000);
    run_line(9'd25, 1'b0, 9'h1FF, 9'h1FE, 16'h0);
    exp_one(0, 1'b0, 1'b0);
    m_ptr[0] = 20'h03000;
    exp_one(0, 1'b0, 1'b1);
    for (int n = 1; n < 8; n++) begin
      exp_one(n, 1'b0, 1'b0);
      exp_one(n, 1'b0, 1'b1);
    end
    run_line(9'd26, 1'b1, SLOT0, 9'h122, 16'h6000);
  endtask

  task automatic test_reset_mid_slot();
    @(negedge clk);
    b.hpos = 9'h000;
    b.vpos = 9'd25;
    b.dmaen = 1'b1;
    @(negedge clk);
    b.hpos = SLOT0;
    #1 tests++;
    if (b.dma !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_slot: dma=%b, expected 1", b.dma);
    end
    reset = 1'b1;
    #1 tests++;
    if (b.dma !== 1'b0 || b.address_out !== 20'h0 || b.reg_address_out !== 8'hFF) begin
      fails++;
      $display("FAIL mid_reset: dma=%b addr=%h reg=%h, expected 0/0/ff", b.dma, b.address_out, b.reg_address_out);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 8; n++) m_ptr[n] = '0;
    exp_all_ctrl();
    run_line(9'd25, 1'b1, 9'h1FF, 9'h1FE, 16'h0);
  endtask

  initial begin
    b.hpos = 9'h100;
    b.vpos = 9'd0;
    b.dmaen = 1'b0;
    b.reg_address_in = 8'hFF;
    b.data_in = 16'h0000;
    test_reset();
    test_ptr_ctrl();
    test_active();
    test_equal_start_stop();
    test_dmaen_and_collision();
    test_reset_mid_slot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sprite_dma.md
# sprite_dma

Agnus-side sprite DMA engine for the eight hardware sprites. Owns the eight sprite pointers and a per-sprite vertical state machine, and claims the fixed sprite slots of each line. In each claimed slot it fetches a word from chip RAM and steers it to the matching SPRxPOS/CTL/DATA/DATB register. It sits directly upstream of the Denise sprite shifters, which consume those register writes from the shared register bus.

## Interface
Parameters:
- SLOT0, 9'h015: hpos (colour clocks) of sprite 0 first slot; sprite n uses SLOT0+4n (slot A) and SLOT0+4n+2 (slot B).
- VBL_END, 9'd25: line on which all sprites begin control fetch.

Ports:
- clk  in  1  bus clock, one colour clock per enabled cycle.
- reset  in  1  asynchronous, active-high.
- hpos  in  9  horizontal beam counter, colour clocks; 0 = line start.
- vpos  in  9  vertical beam counter.
- dmaen  in  1  sprite DMA enable (DMACON SPREN & DMAEN).
- reg_address_in  in  8 ([8:1])  register bus address (CPU, copper or DMA).
- data_in  in  16  register bus data.
- dma  out  1  this block owns the current bus cycle.
- address_out  out  20 ([20:1])  chip RAM word address for the fetch.
- reg_address_out  out  8 ([8:1])  destination register for the fetched word; 9'h1FE (NOP) when dma=0.

## Operation
- Pointer writes: SPRxPTH at 9'h120+4n loads ptr_n[20:16] from data_in[4:0]. SPRxPTL at 9'h122+4n loads ptr_n[15:1] from data_in[15:1].
- POS/CTL snoop: applies to CPU, copper and own DMA writes alike.
  - A write to 9'h140+8n sets vstart_n[7:0]=data_in[15:8].
  - A write to 9'h142+8n sets vstop_n[7:0]=data_in[15:8], vstart_n[8]=data_in[2] and vstop_n[8]=data_in[1].
- Per-sprite state, 2 bits: IDLE, CTRL, WAIT, ACTIVE.
  - Any state -> CTRL at line start (hpos==0) when vpos==VBL_END.
  - CTRL: slot A fetches ->POS (9'h140+8n); slot B fetches ->CTL (9'h142+8n). After the slot B fetch completes -> WAIT.
  - WAIT: at line start, if vpos==vstart_n and vstart_n!=vstop_n -> ACTIVE; otherwise stay.
  - ACTIVE: at line start, if vpos==vstop_n -> CTRL, so the new POS/CTL pair is fetched on the stop line. Otherwise slot A fetches ->DATA (9'h144+8n) and slot B fetches ->DATB (9'h146+8n).
  - IDLE: no fetches.
- Fetch: dma=1 and address_out=ptr_n. ptr_n increments by 1 word, modulo 2^20 (wraps 20'hFFFFF->0), on the following edge.
- When dmaen=0 in a slot: dma=0, no pointer increment, and CTRL does not advance to WAIT. Line-start transitions still evaluate.
- A CPU pointer write coinciding with an own fetch increment: the CPU value wins.
- Slots are fixed: no grant handshake. The bus must accept dma=1 unconditionally.

## Timing
- dma, address_out and reg_address_out are combinational from state, ptr and hpos. They are valid during the slot cycle only.
- Fetched data appears on data_in with reg_address_in equal to the issued reg_address_out. The snoop and the Denise registers capture it at the same clk edge.
- State updates at the clk edge where hpos==0. The new state governs slots on that same line.
- A POS/CTL write on a given line affects vstart/vstop compares from the next line start.
- Reset, asynchronous, at any time including mid-fetch:
  - All states go to IDLE.
  - ptr, vstart and vstop are cleared to 0.
  - dma=0, address_out=0, reg_address_out=9'h1FE.
- Only one sprite slot is active per cycle. Outputs in non-slot cycles: dma=0, address_out=0, reg_address_out=9'h1FE.

## Test plan
- Reset, then run a full line -> dma never 1; reg_address_out=9'h1FE throughout.
- Pointer and control fetch:
  - Stimulus: ptr0=20'h01000, dmaen=1, vpos=25.
  - Slot 9'h015 -> address 20'h01000, reg 9'h140.
  - Slot 9'h017 -> address 20'h01001, reg 9'h142.
  - ptr0 ends at 20'h01002.
- Active window:
  - Stimulus: fetched POS=16'h3040, CTL=16'h3200 (vstart=48, vstop=50).
  - Lines 48 and 49 -> sprite 0 slots issue regs 9'h144 then 9'h146, with ptr +2 per line.
  - Line 50 -> regs 9'h140 then 9'h142.
- dmaen=0 on line 25 -> no dma; sprite stays in CTRL. Re-enable on line 26 -> POS/CTL fetch on line 26.
- vstart==vstop=60 -> no DATA fetch on any line; the sprite stays in WAIT.
- Edge cases:
  - Sprite 7 slots at 9'h031 and 9'h033 -> regs 9'h178 and 9'h17A.
  - ptr7=20'hFFFFF: one fetch -> ptr7 wraps to 0.
  - Assert reset mid-slot -> dma drops to 0 in the same cycle.
